// File: rtl/te_branch_map.sv
// te_branch_map
// -----------------------------------------------------------------------------
// Collects conditional-branch outcomes from the commit-side itype detector
// into an E-Trace style branch map. The map is handed to the packet encoder
// over a valid/ready handshake in two cases:
//   - the map fills up (MAP_LEN branches), or
//   - a non-branch discontinuity (exception, interrupt, eret, uninferable
//     jump) ends the current run of branches.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   valid_i      itype_i qualifies this cycle
//   itype_i      0 none, 1 exception, 2 interrupt, 3 eret,
//                4 nontaken branch, 5 taken branch, 6 updiscon
//   ready_o      block accepts itype_i this cycle (low while a map is pending)
//   flush_i      encoder resync: drop the map being built and any pending map
//   map_valid_o  emitted map available
//   map_ready_i  encoder accepts the emitted map
//   map_o        emitted map, bit k = branch k (oldest at bit 0), 1 = not taken
//   count_o      number of valid branches in map_o
//   reason_o     0 = map full, 1 = discontinuity
// -----------------------------------------------------------------------------
module te_branch_map #(
  parameter int unsigned ITYPE_LEN = 3,
  parameter int unsigned MAP_LEN   = 31,
  localparam int unsigned CNT_W    = $clog2(MAP_LEN + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic [ITYPE_LEN-1:0] itype_i,
  output logic                 ready_o,
  input  logic                 flush_i,
  output logic                 map_valid_o,
  input  logic                 map_ready_i,
  output logic [MAP_LEN-1:0]   map_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 reason_o
);

  localparam logic [ITYPE_LEN-1:0] IT_EXC  = ITYPE_LEN'(1);
  localparam logic [ITYPE_LEN-1:0] IT_INT  = ITYPE_LEN'(2);
  localparam logic [ITYPE_LEN-1:0] IT_ERET = ITYPE_LEN'(3);
  localparam logic [ITYPE_LEN-1:0] IT_NT   = ITYPE_LEN'(4);
  localparam logic [ITYPE_LEN-1:0] IT_TK   = ITYPE_LEN'(5);
  localparam logic [ITYPE_LEN-1:0] IT_UPD  = ITYPE_LEN'(6);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [MAP_LEN-1:0] map_q, map_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAP_LEN-1:0] out_map_q, out_map_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               reason_q, reason_d;

  logic               accept;
  logic               is_nt;
  logic [MAP_LEN-1:0] base_map;
  logic [CNT_W-1:0]   base_cnt;
  logic [MAP_LEN-1:0] new_map;
  logic [CNT_W-1:0]   new_cnt;

  assign map_valid_o = (state_q == EMIT);
  assign ready_o     = ~map_valid_o;
  assign accept      = valid_i & ready_o;
  assign is_nt       = (itype_i == IT_NT);

  assign map_o    = out_map_q;
  assign count_o  = out_cnt_q;
  assign reason_o = reason_q;

  // A flush clears the accumulator first; an input accepted in the same
  // cycle is then applied on top of the empty map.
  assign base_map = flush_i ? '0 : map_q;
  assign base_cnt = flush_i ? '0 : cnt_q;
  assign new_map  = base_map | (MAP_LEN'(is_nt) << base_cnt);
  assign new_cnt  = base_cnt + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    map_d     = map_q;
    cnt_d     = cnt_q;
    out_map_d = out_map_q;
    out_cnt_d = out_cnt_q;
    reason_d  = reason_q;

    if (flush_i) begin
      state_d = COLLECT;
      map_d   = '0;
      cnt_d   = '0;
    end

    if (state_q == COLLECT) begin
      if (accept) begin
        case (itype_i)
          IT_NT, IT_TK: begin
            // The branch that fills the map is emitted together with it.
            if (new_cnt == CNT_W'(MAP_LEN)) begin
              state_d   = EMIT;
              out_map_d = new_map;
              out_cnt_d = new_cnt;
              reason_d  = 1'b0;
              map_d     = '0;
              cnt_d     = '0;
            end else begin
              map_d = new_map;
              cnt_d = new_cnt;
            end
          end
          // The discontinuity itself contributes no bit; an empty map is
          // still emitted so the encoder sees the run boundary.
          IT_EXC, IT_INT, IT_ERET, IT_UPD: begin
            state_d   = EMIT;
            out_map_d = base_map;
            out_cnt_d = base_cnt;
            reason_d  = 1'b1;
            map_d     = '0;
            cnt_d     = '0;
          end
          default: ;
        endcase
      end
    end else if (!flush_i && map_ready_i) begin
      state_d = COLLECT;
    end
  end

  // Emitted-map registers keep their value after the handshake; only reset
  // clears them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= COLLECT;
      map_q     <= '0;
      cnt_q     <= '0;
      out_map_q <= '0;
      out_cnt_q <= '0;
      reason_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      map_q     <= map_d;
      cnt_q     <= cnt_d;
      out_map_q <= out_map_d;
      out_cnt_q <= out_cnt_d;
      reason_q  <= reason_d;
    end
  end

endmodule

// File: tb/tb_te_branch_map.sv
// tb_te_branch_map
// Drives itype codes into te_branch_map. Every map the encoder side accepts
// is popped from a queue of expected maps and compared; a table of vectors
// covers the plain emit cases and hand-written sequences cover back-pressure,
// map-full, flush and asynchronous reset.
module tb_te_branch_map;

  typedef struct {
    logic [30:0] map;
    logic [4:0]  cnt;
    logic        reason;
  } emit_t;

  typedef struct {
    logic [2:0]  itype;
    logic        emit;
    logic [30:0] map;
    logic [4:0]  cnt;
    logic        reason;
  } vec_t;

  logic        clk;
  logic        rstN;
  logic        validIn;
  logic [2:0]  itypeIn;
  logic        readyOut;
  logic        flushIn;
  logic        mapValid;
  logic        mapReady;
  logic [30:0] mapOut;
  logic [4:0]  countOut;
  logic        reasonOut;

  int    errors = 0;
  int    checks = 0;
  emit_t sbq[$];
  vec_t  vecs[12];

  te_branch_map dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .valid_i     (validIn),
    .itype_i     (itypeIn),
    .ready_o     (readyOut),
    .flush_i     (flushIn),
    .map_valid_o (mapValid),
    .map_ready_i (mapReady),
    .map_o       (mapOut),
    .count_o     (countOut),
    .reason_o    (reasonOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; presents one itype once ready_o allows
  // it and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [2:0] it);
    int guard = 0;
    while (!readyOut && guard < 100) begin
      tick();
      guard++;
    end
    if (!readyOut) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready timeout: got ready_o=0 expected 1 at %0t", $time);
    end else begin
      validIn = 1'b1;
      itypeIn = it;
      tick();
      validIn = 1'b0;
      itypeIn = 3'd0;
    end
  endtask

  // Compare every map the encoder side takes against the scoreboard.
  always @(negedge clk) begin
    if (rstN && mapValid && mapReady && !flushIn) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected emit: got count=%0d map=0x%0h expected no emit", countOut, mapOut);
      end else begin
        emit_t e;
        e = sbq.pop_front();
        checkOutput("emit map", {1'b0, mapOut}, {1'b0, e.map});
        checkOutput("emit count", {27'd0, countOut}, {27'd0, e.cnt});
        checkOutput("emit reason", {31'd0, reasonOut}, {31'd0, e.reason});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{3'd4, 1'b0, 31'd0,     5'd0, 1'b0};
    vecs[1]  = '{3'd5, 1'b0, 31'd0,     5'd0, 1'b0};
    vecs[2]  = '{3'd4, 1'b0, 31'd0,     5'd0, 1'b0};
    vecs[3]  = '{3'd1, 1'b1, 31'b101,   5'd3, 1'b1};
    vecs[4]  = '{3'd2, 1'b1, 31'd0,     5'd0, 1'b1};
    vecs[5]  = '{3'd0, 1'b0, 31'd0,     5'd0, 1'b0};
    vecs[6]  = '{3'd7, 1'b0, 31'd0,     5'd0, 1'b0};
    vecs[7]  = '{3'd5, 1'b0, 31'd0,     5'd0, 1'b0};
    vecs[8]  = '{3'd5, 1'b0, 31'd0,     5'd0, 1'b0};
    vecs[9]  = '{3'd3, 1'b1, 31'd0,     5'd2, 1'b1};
    vecs[10] = '{3'd4, 1'b0, 31'd0,     5'd0, 1'b0};
    vecs[11] = '{3'd6, 1'b1, 31'd1,     5'd1, 1'b1};

    rstN     = 1'b0;
    validIn  = 1'b0;
    itypeIn  = 3'd0;
    flushIn  = 1'b0;
    mapReady = 1'b0;
    #23;
    rstN = 1'b1;
    tick();

    // Idle after reset.
    repeat (10) tick();
    checkOutput("reset valid", {31'd0, mapValid}, 32'd0);
    checkOutput("reset ready", {31'd0, readyOut}, 32'd1);
    checkOutput("reset count", {27'd0, countOut}, 32'd0);
    checkOutput("reset map", {1'b0, mapOut}, 32'd0);

    // T,N,N,T then updiscon with back-pressure.
    applyStimulus(3'd5);
    applyStimulus(3'd4);
    applyStimulus(3'd4);
    applyStimulus(3'd5);
    sbq.push_back('{31'b0110, 5'd4, 1'b1});
    applyStimulus(3'd6);
    checkOutput("disc valid", {31'd0, mapValid}, 32'd1);
    checkOutput("disc count", {27'd0, countOut}, 32'd4);
    checkOutput("disc map", {1'b0, mapOut}, 32'b0110);
    checkOutput("disc reason", {31'd0, reasonOut}, 32'd1);
    repeat (3) begin
      tick();
      checkOutput("hold valid", {31'd0, mapValid}, 32'd1);
      checkOutput("hold ready", {31'd0, readyOut}, 32'd0);
      checkOutput("hold map", {1'b0, mapOut}, 32'b0110);
    end
    mapReady = 1'b1;
    tick();
    mapReady = 1'b0;
    checkOutput("handshake valid", {31'd0, mapValid}, 32'd0);
    checkOutput("handshake ready", {31'd0, readyOut}, 32'd1);
    checkOutput("kept count", {27'd0, countOut}, 32'd4);

    // 31 nontaken branches fill the map.
    for (int i = 0; i < 30; i++) applyStimulus(3'd4);
    checkOutput("30 valid", {31'd0, mapValid}, 32'd0);
    sbq.push_back('{31'h7FFFFFFF, 5'd31, 1'b0});
    applyStimulus(3'd4);
    checkOutput("full valid", {31'd0, mapValid}, 32'd1);
    checkOutput("full count", {27'd0, countOut}, 32'd31);
    checkOutput("full map", {1'b0, mapOut}, 32'h7FFFFFFF);
    checkOutput("full reason", {31'd0, reasonOut}, 32'd0);
    mapReady = 1'b1;
    sbq.push_back('{31'd0, 5'd0, 1'b1});
    applyStimulus(3'd1);
    checkOutput("after full valid", {31'd0, mapValid}, 32'd1);
    checkOutput("after full count", {27'd0, countOut}, 32'd0);
    tick();

    // Table of vectors with the encoder always ready.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].emit) sbq.push_back('{vecs[i].map, vecs[i].cnt, vecs[i].reason});
      applyStimulus(vecs[i].itype);
      checkOutput($sformatf("row%0d valid", i), {31'd0, mapValid}, {31'd0, vecs[i].emit});
    end
    tick();

    // Flush abandons a pending map.
    mapReady = 1'b0;
    applyStimulus(3'd5);
    applyStimulus(3'd5);
    applyStimulus(3'd6);
    checkOutput("pend valid", {31'd0, mapValid}, 32'd1);
    flushIn = 1'b1;
    tick();
    flushIn = 1'b0;
    checkOutput("flush valid", {31'd0, mapValid}, 32'd0);
    checkOutput("flush ready", {31'd0, readyOut}, 32'd1);
    mapReady = 1'b1;
    applyStimulus(3'd4);
    sbq.push_back('{31'd1, 5'd1, 1'b1});
    applyStimulus(3'd3);
    checkOutput("post flush count", {27'd0, countOut}, 32'd1);
    tick();

    // Flush with a branch in the same cycle: branch lands on the empty map.
    applyStimulus(3'd5);
    applyStimulus(3'd5);
    flushIn = 1'b1;
    validIn = 1'b1;
    itypeIn = 3'd4;
    tick();
    flushIn = 1'b0;
    validIn = 1'b0;
    itypeIn = 3'd0;
    sbq.push_back('{31'd1, 5'd1, 1'b1});
    applyStimulus(3'd6);
    tick();

    // Asynchronous reset with branches collected.
    mapReady = 1'b0;
    repeat (5) applyStimulus(3'd5);
    #2 rstN = 1'b0;
    #1;
    checkOutput("async count", {27'd0, countOut}, 32'd0);
    checkOutput("async map", {1'b0, mapOut}, 32'd0);
    checkOutput("async reason", {31'd0, reasonOut}, 32'd0);
    #2 rstN = 1'b1;
    tick();
    mapReady = 1'b1;
    sbq.push_back('{31'd0, 5'd0, 1'b1});
    applyStimulus(3'd6);
    checkOutput("reset emit count", {27'd0, countOut}, 32'd0);
    tick();

    // Asynchronous reset while a map is pending.
    mapReady = 1'b0;
    applyStimulus(3'd4);
    applyStimulus(3'd2);
    checkOutput("pend2 valid", {31'd0, mapValid}, 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("async valid", {31'd0, mapValid}, 32'd0);
    checkOutput("async ready", {31'd0, readyOut}, 32'd1);
    checkOutput("async count2", {27'd0, countOut}, 32'd0);
    #2 rstN = 1'b1;
    tick();
    tick();

    checkOutput("scoreboard empty", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/te_branch_map.md
Name: te_branch_map

Overview:
- Consumer of the per-cycle instruction-type code produced by the commit-side itype detector.
- Accumulates conditional-branch outcomes into an E-Trace-style branch map of up to 31 entries.
- Emits the map to the packet encoder through a valid/ready handshake when the map fills or when a non-branch discontinuity (exception, interrupt, eret, uninferable jump) ends the current branch run.
- Sits between the itype detector and the packet emitter in the trace encoder pipeline.

Parameters:
- ITYPE_LEN, 3, width of itype code (matches mure_pkg; values 0..6 used).
- MAP_LEN, 31, maximum branches per map (count width = $clog2(MAP_LEN+1) = 5).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  itype_i qualifies this cycle.
- itype_i  input  ITYPE_LEN  0 none, 1 exception, 2 interrupt, 3 eret, 4 nontaken branch, 5 taken branch, 6 updiscon.
- ready_o  output  1  block accepts itype_i this cycle.
- flush_i  input  1  encoder resync; discard map and any pending output.
- map_valid_o  output  1  emitted map available.
- map_ready_i  input  1  encoder accepts emitted map.
- map_o  output  MAP_LEN  emitted map; bit k = branch k (oldest at bit 0); 1 = not taken, 0 = taken; bits >= count are 0.
- count_o  output  5  number of valid branches in map_o (0..31).
- reason_o  output  1  0 = map full, 1 = discontinuity.

Behaviour:
- Reset (async, rst_ni=0): map, count, map_o, count_o, reason_o, map_valid_o all 0; state COLLECT; ready_o=1 on release.
- ready_o = ~map_valid_o (combinational from the register). An input is accepted when valid_i && ready_o. While ready_o=0, valid_i and itype_i are ignored; the upstream stage holds them.
- States:
  - COLLECT: map_valid_o=0.
  - EMIT: map_valid_o=1; map_o, count_o and reason_o are held stable until the handshake.
- COLLECT, accepted itype 4 or 5:
  - map[count] <= (itype==4); count <= count+1.
  - If the new count == 31: next cycle enter EMIT with map_o = full map, count_o=31, reason_o=0. Internal map and count clear to 0.
- COLLECT, accepted itype 1, 2, 3 or 6:
  - Next cycle enter EMIT with the current map and count (count 0 allowed; emitted with count_o=0) and reason_o=1. Internal map and count clear.
  - The discontinuity instruction itself adds no bit.
- COLLECT, accepted itype 0 or values 7+: no state change.
- Latency: the triggering input is accepted in cycle N; map_valid_o=1 in N+1.
- EMIT with map_ready_i=1: handshake completes. Next cycle map_valid_o=0, state COLLECT, ready_o=1. map_o, count_o and reason_o keep their last value; they are don't-care when invalid but are not cleared.
- flush_i (synchronous, highest priority after reset):
  - Clears internal map and count, and drops map_valid_o to 0 (pending map abandoned, no handshake required). State returns to COLLECT next cycle.
  - An input presented in the same cycle as flush_i is accepted only if ready_o=1. In that case it is applied after the clear, so a branch becomes bit 0 with count 1.
- Simultaneous full + discontinuity cannot occur: one itype per cycle.
- The 31st branch always triggers a full emit. The following discontinuity emits count_o=0, reason_o=1.
- Reset asserted mid-EMIT: pending map lost, outputs 0 immediately (asynchronous).

Test Plan:
- Reset release, idle inputs 10 cycles -> map_valid_o=0, ready_o=1, count_o=0, map_o=0.
- Branches T,N,N,T then itype 6 -> one cycle later map_valid_o=1, count_o=4, map_o=31'b0110, reason_o=1. Hold map_ready_i=0 for 3 cycles -> outputs stable and ready_o=0. Then map_ready_i=1 -> map_valid_o=0 next cycle.
- 31 consecutive nontaken branches -> map_valid_o=1, count_o=31, map_o=31'h7FFFFFFF, reason_o=0. Accept it, then send itype 1 -> emit with count_o=0, map_o=0, reason_o=1.
- Itype 2 with no prior branches -> emit count_o=0, reason_o=1. Itype 0 and 7 afterwards -> no emit.
- Pending EMIT with map_ready_i=0, assert flush_i -> map_valid_o=0 next cycle. Then branch N -> internal count 1. A later itype 3 emits count_o=1, map_o=1.
- 5 branches collected, pulse rst_ni=0 mid-cycle -> all outputs 0 immediately. After release, itype 6 -> emit count_o=0.
